apb_master_ctrl: RTL and testbench

APB_MASTER_CTRL -- requirements
Module: apb_master_ctrl

---
 rtl/apb_master_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_apb_master_ctrl.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_ctrl.sv
// apb_master_ctrl: queued APB master. Commands enter a small FIFO and are
// issued as APB transfers; every finished transfer produces a one-cycle
// response pulse on rsp_valid.
// Optional feature macro: APB_MASTER_TIMEOUT_EN. When defined, an ACCESS
// phase that sees no pready for TIMEOUT cycles is aborted and reported as an
// error with rsp_timeout set. When undefined, ACCESS waits indefinitely.
//
// state  | meaning
// IDLE   | no transfer; pops the FIFO head as soon as one is queued
// SETUP  | address phase, psel=1 penable=0
// ACCESS | data phase, psel=1 penable=1, waiting for pready (or timeout)
module apb_master_ctrl #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int CMD_DEPTH = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              busy,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    localparam int PTR_W = $clog2(CMD_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = 1 + ADDR_W + DATA_W;

    if (CMD_DEPTH < 2 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0 || TIMEOUT < 2) begin : g_param_check
        $error("apb_master_ctrl: CMD_DEPTH must be a power of 2 >= 2 and TIMEOUT >= 2");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [ENT_W-1:0] fifo_mem [CMD_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count, count_nxt;
    logic             push, pop, fifo_empty;
    logic             done_ok, done_to, tmo_hit;

    assign push       = cmd_valid && cmd_ready;
    assign fifo_empty = (count == '0);
    assign count_nxt  = count + CNT_W'(push) - CNT_W'(pop);
    assign busy       = !fifo_empty || (state != ST_IDLE);
    assign psel       = (state != ST_IDLE);
    assign penable    = (state == ST_ACCESS);

    // Command storage; no reset needed because count gates every read.
    always_ff @(posedge pclk) begin
        if (push) fifo_mem[wr_ptr] <= {cmd_write, cmd_addr, cmd_wdata};
    end

    // FIFO pointers, occupancy and the registered ready flag.
    always_ff @(posedge pclk) begin
        if (preset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            cmd_ready <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count     <= count_nxt;
            cmd_ready <= (count_nxt != CNT_W'(CMD_DEPTH));
        end
    end

    // FSM state register.
    always_ff @(posedge pclk) begin
        if (preset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next state, FIFO pop and completion decode; back-to-back skips IDLE.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        done_ok   = 1'b0;
        done_to   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: state_nxt = ST_ACCESS;
            ST_ACCESS: begin
                if (pready)       done_ok = 1'b1;
                else if (tmo_hit) done_to = 1'b1;
                if (pready || tmo_hit) begin
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        state_nxt = ST_SETUP;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // APB address/data are captured at pop and held through ACCESS.
    always_ff @(posedge pclk) begin
        if (preset) begin
            pwrite <= 1'b0;
            paddr  <= '0;
            pwdata <= '0;
        end else if (pop) begin
            {pwrite, paddr, pwdata} <= fifo_mem[rd_ptr];
        end
    end

    // Response pulse; data/error hold their last value between pulses.
    always_ff @(posedge pclk) begin
        if (preset) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= done_ok || done_to;
            if (done_ok) begin
                rsp_rdata <= pwrite ? '0 : prdata;
                rsp_err   <= pslverr;
            end else if (done_to) begin
                rsp_rdata <= '0;
                rsp_err   <= 1'b1;
            end
        end
    end

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT);

    logic [TMO_W-1:0] tmo_cnt;
    logic             rsp_tmo_q;

    // Down-counter loaded in SETUP; reaching zero in ACCESS means TIMEOUT
    // ACCESS cycles have passed without pready.
    always_ff @(posedge pclk) begin
        if (preset) begin
            tmo_cnt   <= '0;
            rsp_tmo_q <= 1'b0;
        end else begin
            if (state == ST_SETUP)
                tmo_cnt <= TMO_W'(TIMEOUT - 1);
            else if (state == ST_ACCESS && tmo_cnt != '0)
                tmo_cnt <= tmo_cnt - TMO_W'(1);
            if (done_ok)      rsp_tmo_q <= 1'b0;
            else if (done_to) rsp_tmo_q <= 1'b1;
        end
    end

    assign tmo_hit     = (tmo_cnt == '0);
    assign rsp_timeout = rsp_tmo_q;
`else
    assign tmo_hit     = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Testbench for apb_master_ctrl: a behavioural APB slave with per-transfer
// wait states predicts every response and checks ordering and protocol.
`timescale 1ns/1ps
module tb_apb_master_ctrl;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int CMD_DEPTH = 4;
    localparam int TIMEOUT   = 16;

    logic              pclk = 1'b0;
    logic              preset = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_write = 1'b0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [DATA_W-1:0] cmd_wdata = '0;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;
    logic              busy;
    logic              psel, penable, pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata = '0;
    logic              pready = 1'b0;
    logic              pslverr = 1'b0;

    always #5 pclk = ~pclk;

    apb_master_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CMD_DEPTH(CMD_DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .pclk(pclk), .preset(preset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout), .busy(busy),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: accepted commands in order, expected responses in order.
    logic [64:0] cmd_q[$];
    logic [33:0] exp_q[$];

    // Slave behaviour configuration.
    bit          stall = 1'b0;
    bit          cfg_rand = 1'b0;
    int          cfg_wait = 0;
    logic [31:0] cfg_rdata = '0;
    bit          cfg_err = 1'b0;

    bit          rsp_due = 1'b0;
    int          acc_cycles = 0;
    int          cur_wait = 0;
    logic        cur_write = 1'b0;
    logic [31:0] cur_addr = '0, cur_wdata = '0, cur_rdata = '0;
    bit          cur_err = 1'b0;
    logic [33:0] last_rsp = '0;

    // Slave model and protocol monitor, acting between rising edges.
    always @(negedge pclk) begin
        logic [64:0] c;
        logic [33:0] e;
        if (preset) begin
            pready = 1'b0; pslverr = 1'b0; prdata = '0;
            acc_cycles = 0; rsp_due = 1'b0;
            cmd_q.delete(); exp_q.delete();
            last_rsp = '0;
        end else begin
            n_checks++;
            if (rsp_valid !== rsp_due) begin
                n_fail++;
                $display("FAIL rsp_timing: rsp_valid=%b required=%b at %0t", rsp_valid, rsp_due, $time);
            end
            if (rsp_valid === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rsp_unexpected: got rdata=%h err=%b tmo=%b, required none", rsp_rdata, rsp_err, rsp_timeout);
                end else begin
                    e = exp_q.pop_front();
                    if ({rsp_rdata, rsp_err, rsp_timeout} !== e) begin
                        n_fail++;
                        $display("FAIL rsp_content: got rdata=%h err=%b tmo=%b, required rdata=%h err=%b tmo=%b",
                                 rsp_rdata, rsp_err, rsp_timeout, e[33:2], e[1], e[0]);
                    end
                end
                last_rsp = {rsp_rdata, rsp_err, rsp_timeout};
            end else begin
                n_checks++;
                if ({rsp_rdata, rsp_err, rsp_timeout} !== last_rsp) begin
                    n_fail++;
                    $display("FAIL rsp_hold: got %h, required %h", {rsp_rdata, rsp_err, rsp_timeout}, last_rsp);
                end
            end
            rsp_due = 1'b0;
            n_checks++;
            if (penable === 1'b1 && psel !== 1'b1) begin
                n_fail++;
                $display("FAIL penable_without_psel: psel=%b penable=%b", psel, penable);
            end
            pready = 1'b0; pslverr = 1'b0; prdata = $urandom;
            if (psel === 1'b1 && penable === 1'b0) begin
                n_checks++;
                if (cmd_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL setup_unexpected: addr=%h, required no transfer", paddr);
                end else begin
                    c = cmd_q.pop_front();
                    if ({pwrite, paddr, pwdata} !== c) begin
                        n_fail++;
                        $display("FAIL setup_cmd: got w=%b a=%h d=%h, required w=%b a=%h d=%h",
                                 pwrite, paddr, pwdata, c[64], c[63:32], c[31:0]);
                    end
                end
                cur_write = pwrite; cur_addr = paddr; cur_wdata = pwdata;
                acc_cycles = 0;
                if (cfg_rand) begin
                    cur_wait  = int'($urandom_range(0, 4));
                    cur_rdata = $urandom;
                    cur_err   = ($urandom_range(0, 3) == 0);
                end else begin
                    cur_wait  = cfg_wait;
                    cur_rdata = cfg_rdata;
                    cur_err   = cfg_err;
                end
            end else if (psel === 1'b1 && penable === 1'b1) begin
                n_checks++;
                if ({pwrite, paddr, pwdata} !== {cur_write, cur_addr, cur_wdata}) begin
                    n_fail++;
                    $display("FAIL access_stable: got w=%b a=%h d=%h, required w=%b a=%h d=%h",
                             pwrite, paddr, pwdata, cur_write, cur_addr, cur_wdata);
                end
                if (!stall && acc_cycles >= cur_wait) begin
                    pready = 1'b1; pslverr = cur_err; prdata = cur_rdata;
                    exp_q.push_back({cur_write ? 32'd0 : cur_rdata, cur_err, 1'b0});
                    rsp_due = 1'b1;
                end
`ifdef APB_MASTER_TIMEOUT_EN
                else if (acc_cycles == TIMEOUT - 1) begin
                    exp_q.push_back({32'd0, 1'b1, 1'b1});
                    rsp_due = 1'b1;
                end
`endif
                acc_cycles++;
            end
        end
    end

    task automatic drive_cmd(input logic w, input logic [31:0] a, input logic [31:0] d);
        bit done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge pclk);
            cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
            if (cmd_ready === 1'b1) begin
                cmd_q.push_back({w, a, d});
                done = 1'b1;
            end
        end
        if (!done) begin
            n_checks++; n_fail++;
            $display("FAIL cmd_accept_timeout: cmd_ready=%b, required 1 within 200 cycles", cmd_ready);
        end
    endtask

    task automatic drive_idle();
        @(negedge pclk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int i;
        for (i = 0; i < 2000; i++) begin
            @(negedge pclk);
            if (busy === 1'b0) break;
        end
        repeat (3) @(negedge pclk);
        n_checks++;
        if (i == 2000 || exp_q.size() != 0 || cmd_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: busy=%b pending_rsp=%0d pending_cmd=%0d, required 0/0/0",
                     busy, exp_q.size(), cmd_q.size());
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge pclk);
        n_checks++;
        if ({cmd_ready, busy, psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err, rsp_timeout} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: cmd_ready=%b busy=%b psel=%b penable=%b paddr=%h rsp_valid=%b, required all 0",
                     cmd_ready, busy, psel, penable, paddr, rsp_valid);
        end
        preset = 1'b0;
        @(negedge pclk);
        n_checks++;
        if ({cmd_ready, busy, psel} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_release: cmd_ready=%b busy=%b psel=%b, required 1 0 0", cmd_ready, busy, psel);
        end
    endtask

    task automatic test_single_write();
        cfg_rand = 1'b0; cfg_wait = 0; cfg_err = 1'b0; cfg_rdata = 32'hDEAD_BEEF;
        drive_cmd(1'b1, 32'h7000_0000, 32'd6);
        drive_idle();
        n_checks++;
        if ({psel, busy} !== 2'b01) begin
            n_fail++; $display("FAIL wr_accept: psel=%b busy=%b, required 0 1", psel, busy);
        end
        @(negedge pclk);
        n_checks++;
        if ({psel, penable, pwrite, paddr, pwdata} !== {3'b101, 32'h7000_0000, 32'd6}) begin
            n_fail++; $display("FAIL wr_setup: psel=%b penable=%b pwrite=%b paddr=%h pwdata=%h, required 1 0 1 70000000 6",
                               psel, penable, pwrite, paddr, pwdata);
        end
        @(negedge pclk);
        n_checks++;
        if ({psel, penable} !== 2'b11) begin
            n_fail++; $display("FAIL wr_access: psel=%b penable=%b, required 1 1", psel, penable);
        end
        @(negedge pclk);
        n_checks++;
        if ({psel, penable, rsp_valid, rsp_err, rsp_rdata} !== {3'b001, 1'b0, 32'd0}) begin
            n_fail++; $display("FAIL wr_rsp: psel=%b penable=%b rsp_valid=%b rsp_err=%b rdata=%h, required 0 0 1 0 0",
                               psel, penable, rsp_valid, rsp_err, rsp_rdata);
        end
        @(negedge pclk);
        n_checks++;
        if ({rsp_valid, busy} !== 2'b00) begin
            n_fail++; $display("FAIL wr_after: rsp_valid=%b busy=%b, required 0 0", rsp_valid, busy);
        end
    endtask

    task automatic test_wait_read();
        int pen = 0;
        bit found = 1'b0;
        cfg_rand = 1'b0; cfg_wait = 3; cfg_err = 1'b0; cfg_rdata = 32'd9;
        drive_cmd(1'b0, 32'h7000_0004, $urandom);
        drive_idle();
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge pclk);
            if (rsp_valid === 1'b1) found = 1'b1;
            else if (penable === 1'b1) pen++;
        end
        n_checks++;
        if (!found || pen != 4 || rsp_rdata !== 32'd9 || rsp_err !== 1'b0) begin
            n_fail++; $display("FAIL rd_wait: found=%b penable_cycles=%0d rdata=%h err=%b, required 1 4 9 0",
                               found, pen, rsp_rdata, rsp_err);
        end
        wait_drain();
    endtask

    task automatic test_slverr();
        bit found = 1'b0;
        cfg_rand = 1'b0; cfg_wait = 1; cfg_err = 1'b1; cfg_rdata = $urandom;
        drive_cmd(1'b0, $urandom, $urandom);
        drive_idle();
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge pclk);
            if (rsp_valid === 1'b1) found = 1'b1;
        end
        n_checks++;
        if (!found || rsp_err !== 1'b1 || rsp_timeout !== 1'b0 || rsp_rdata !== cfg_rdata) begin
            n_fail++; $display("FAIL slverr: found=%b err=%b tmo=%b rdata=%h, required 1 1 0 %h",
                               found, rsp_err, rsp_timeout, rsp_rdata, cfg_rdata);
        end
        cfg_err = 1'b0;
        wait_drain();
    endtask

    task automatic test_back_to_back();
        int got = 0;
        int gap = 0;
        stall = 1'b1; cfg_rand = 1'b1;
        for (int i = 0; i < 5; i++) drive_cmd(1'($urandom_range(0, 1)), $urandom, $urandom);
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            cmd_valid = 1'b1; cmd_addr = $urandom; cmd_wdata = $urandom;
            n_checks++;
            if ({cmd_ready, busy, penable} !== 3'b011) begin
                n_fail++; $display("FAIL fifo_full: cmd_ready=%b busy=%b penable=%b, required 0 1 1",
                                   cmd_ready, busy, penable);
            end
        end
        @(negedge pclk);
        cmd_valid = 1'b0;
        stall = 1'b0;
        for (int i = 0; i < 200 && got < 5; i++) begin
            @(negedge pclk);
            if (rsp_valid === 1'b1) got++;
            if (got < 5 && psel !== 1'b1) gap++;
        end
        n_checks++;
        if (got != 5 || gap != 0) begin
            n_fail++; $display("FAIL back_to_back: responses=%0d idle_gaps=%0d, required 5 0", got, gap);
        end
        wait_drain();
    endtask

    task automatic test_random();
        stall = 1'b0; cfg_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            drive_cmd(1'($urandom_range(0, 1)), $urandom, $urandom);
            repeat ($urandom_range(0, 2)) drive_idle();
        end
        drive_idle();
        wait_drain();
    endtask

    task automatic test_reset_mid();
        stall = 1'b1; cfg_rand = 1'b1;
        for (int i = 0; i < 3; i++) drive_cmd(1'($urandom_range(0, 1)), $urandom, $urandom);
        drive_idle();
        n_checks++;
        if ({psel, penable, busy} !== 3'b111) begin
            n_fail++; $display("FAIL mid_pre: psel=%b penable=%b busy=%b, required 1 1 1", psel, penable, busy);
        end
        preset = 1'b1;
        @(negedge pclk);
        n_checks++;
        if ({cmd_ready, busy, psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err, rsp_timeout} !== '0) begin
            n_fail++; $display("FAIL mid_reset: cmd_ready=%b busy=%b psel=%b penable=%b paddr=%h rsp_valid=%b, required all 0",
                               cmd_ready, busy, psel, penable, paddr, rsp_valid);
        end
        preset = 1'b0;
        stall = 1'b0;
        @(negedge pclk);
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL mid_ready: cmd_ready=%b, required 1", cmd_ready);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge pclk);
            n_checks++;
            if ({rsp_valid, psel, busy} !== 3'b000) begin
                n_fail++; $display("FAIL mid_discard: rsp_valid=%b psel=%b busy=%b, required 0 0 0", rsp_valid, psel, busy);
            end
        end
    endtask

`ifdef APB_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        int pen = 0;
        bit found = 1'b0;
        stall = 1'b1; cfg_rand = 1'b0; cfg_wait = 0; cfg_err = 1'b0; cfg_rdata = 32'd5;
        drive_cmd(1'b0, $urandom, $urandom);
        drive_cmd(1'b0, $urandom, $urandom);
        drive_idle();
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge pclk);
            if (rsp_valid === 1'b1) found = 1'b1;
            else if (penable === 1'b1) pen++;
        end
        n_checks++;
        if (!found || pen != TIMEOUT || {rsp_rdata, rsp_err, rsp_timeout} !== {32'd0, 2'b11}) begin
            n_fail++; $display("FAIL timeout_abort: found=%b access_cycles=%0d rdata=%h err=%b tmo=%b, required 1 %0d 0 1 1",
                               found, pen, rsp_rdata, rsp_err, rsp_timeout, TIMEOUT);
        end
        n_checks++;
        if ({psel, penable} !== 2'b10) begin
            n_fail++; $display("FAIL timeout_next: psel=%b penable=%b, required 1 0", psel, penable);
        end
        stall = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge pclk);
            if (rsp_valid === 1'b1) found = 1'b1;
        end
        n_checks++;
        if (!found || {rsp_rdata, rsp_err, rsp_timeout} !== {32'd5, 2'b00}) begin
            n_fail++; $display("FAIL timeout_follow: found=%b rdata=%h err=%b tmo=%b, required 1 5 0 0",
                               found, rsp_rdata, rsp_err, rsp_timeout);
        end
        wait_drain();
    endtask
`endif

    initial begin
        test_reset();
        test_single_write();
        test_wait_read();
        test_slverr();
        test_back_to_back();
        test_random();
`ifdef APB_MASTER_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
